// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO writes and MFHI/MFLO reads.
// Latency: accepted op busy for WIDTH+1 cycles (RUN x WIDTH, FIX x 1); divide-by-zero busy 1 cycle.
// Backpressure: md_o_stall holds off any op or read request while busy; requester re-presents it.
// Ports: md_i_clk/md_i_rst_n (sync active-low), md_i_valid/md_i_op/md_i_rs/md_i_rt request,
//        md_i_rd_req/md_i_rd_sel read, md_i_flush abort, md_o_rdata/md_o_busy/md_o_stall/md_o_done.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             md_i_clk,
  input  logic             md_i_rst_n,
  input  logic             md_i_valid,
  input  logic [2:0]       md_i_op,
  input  logic [WIDTH-1:0] md_i_rs,
  input  logic [WIDTH-1:0] md_i_rt,
  input  logic             md_i_rd_req,
  input  logic             md_i_rd_sel,
  input  logic             md_i_flush,
  output logic [WIDTH-1:0] md_o_rdata,
  output logic             md_o_busy,
  output logic             md_o_stall,
  output logic             md_o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  // Multiply: acc[2W-1:0] is the product register, multiplier in the low half.
  // Divide:   acc[2W:W] is the (W+1)-bit remainder, acc[W-1:0] dividend shifting into quotient.
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;           // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;

  logic                 op_mul, op_div, op_signed, op_nop;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH:0]     mul_next, div_next;
  logic [WIDTH+1:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op_mul    = (md_i_op == 3'd1) || (md_i_op == 3'd2);
  assign op_div    = (md_i_op == 3'd3) || (md_i_op == 3'd4);
  assign op_signed = (md_i_op == 3'd1) || (md_i_op == 3'd3);
  assign op_nop    = (md_i_op == 3'd0) || (md_i_op == 3'd7);
  assign rs_mag    = (op_signed && md_i_rs[WIDTH-1]) ? -md_i_rs : md_i_rs;
  assign rt_mag    = (op_signed && md_i_rt[WIDTH-1]) ? -md_i_rt : md_i_rt;

  // Shift-add: add multiplicand to the upper half when the current multiplier bit is set,
  // then shift the whole product right, keeping the add carry.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder, trial-subtract,
  // keep the difference only if it did not borrow.
  assign div_shift = {acc_q[2*WIDTH:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, b_q};
  assign div_next  = div_diff[WIDTH+1]
                   ? {div_shift[WIDTH:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge md_i_clk) begin
    if (!md_i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    md_o_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (md_i_valid && !md_i_flush) begin
          if (op_mul || op_div) begin
            cnt_d     = '0;
            is_div_d  = op_div;
            b_d       = op_div ? rt_mag : rs_mag;
            neg_res_d = op_signed && (md_i_rs[WIDTH-1] ^ md_i_rt[WIDTH-1]);
            neg_rem_d = op_signed && op_div && md_i_rs[WIDTH-1];
            acc_d     = {{(WIDTH+1){1'b0}}, op_div ? rs_mag : rt_mag};
            state_d   = S_RUN;
            // Divide by zero: preload the raw result and let FIX write it unmodified.
            if (op_div && (md_i_rt == '0)) begin
              acc_d     = {1'b0, md_i_rs, {WIDTH{1'b1}}};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_FIX;
            end
          end else if (md_i_op == 3'd5) begin
            hi_d = md_i_rs;
          end else if (md_i_op == 3'd6) begin
            lo_d = md_i_rs;
          end
        end
      end
      S_RUN: begin
        if (md_i_flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!md_i_flush) begin
          md_o_done = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md_o_busy  = (state_q != S_IDLE);
  assign md_o_stall = md_o_busy && ((md_i_valid && !op_nop) || md_i_rd_req);
  assign md_o_rdata = md_i_rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic results, latency, stall, flush and reset scenarios.
// Expected HI/LO pairs are queued when an op is issued and popped when the op retires.
// Inputs driven on the falling edge; outputs sampled on the falling edge or #1 after it.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic [2:0]   op;
  logic [W-1:0] rs, rt;
  logic         rd_req, rd_sel, flush;
  logic [W-1:0] rdata;
  logic         busy, stall, done;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .md_i_clk(clk), .md_i_rst_n(rst_n), .md_i_valid(valid), .md_i_op(op),
    .md_i_rs(rs), .md_i_rt(rt), .md_i_rd_req(rd_req), .md_i_rd_sel(rd_sel),
    .md_i_flush(flush), .md_o_rdata(rdata), .md_o_busy(busy),
    .md_o_stall(stall), .md_o_done(done)
  );

  // Issue one op, count busy cycles and done pulses, then pop the scoreboard and compare HI/LO.
  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int exp_busy);
    int nb, nd;
    logic [2*W-1:0] exp;
    logic [W-1:0] got_hi, got_lo;
    nb = 0; nd = 0;
    @(negedge clk);
    valid = 1'b1; op = o; rs = a; rt = b;
    sb_q.push_back({ehi, elo});
    @(negedge clk);
    valid = 1'b0; op = 3'd0;
    for (int i = 0; i < 100 && busy; i++) begin
      nb++;
      if (done) nd++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s timeout: busy=%b required 0", name, busy);
    end
    checks++;
    if (nb !== exp_busy) begin
      errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, nb, exp_busy);
    end
    checks++;
    if (nd !== 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d required 1", name, nd);
    end
    exp = sb_q.pop_front();
    rd_sel = 1'b1; #1 got_hi = rdata;
    rd_sel = 1'b0; #1 got_lo = rdata;
    checks++;
    if (got_hi !== exp[2*W-1:W]) begin
      errors++; $display("FAIL %s HI: got %h required %h", name, got_hi, exp[2*W-1:W]);
    end
    checks++;
    if (got_lo !== exp[W-1:0]) begin
      errors++; $display("FAIL %s LO: got %h required %h", name, got_lo, exp[W-1:0]);
    end
  endtask

  task automatic write_mt(input logic [2:0] o, input logic [W-1:0] d);
    @(negedge clk);
    valid = 1'b1; op = o; rs = d;
    @(negedge clk);
    valid = 1'b0; op = 3'd0;
  endtask

  task automatic check_hilo(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    logic [W-1:0] h, l;
    rd_sel = 1'b1; #1 h = rdata;
    rd_sel = 1'b0; #1 l = rdata;
    checks++;
    if (h !== ehi) begin errors++; $display("FAIL %s HI: got %h required %h", name, h, ehi); end
    checks++;
    if (l !== elo) begin errors++; $display("FAIL %s LO: got %h required %h", name, l, elo); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; op = 3'd0; rs = '0; rt = '0;
    rd_req = 1'b0; rd_sel = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, stall, done} !== 3'b000) begin
      errors++; $display("FAIL reset flags: busy/stall/done=%b required 000", {busy, stall, done});
    end
    check_hilo("reset", '0, '0);
  endtask

  task automatic test_mul();
    run_op("mult_neg",  3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 33);
    run_op("multu",     3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 33);
    run_op("mult_both", 3'd1, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'h0, 32'd21, 33);
  endtask

  task automatic test_div();
    run_op("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("div_negb",  3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
    run_op("divu",      3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("divu_zero", 3'd4, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1);
    run_op("div_zero",  3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    run_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
  endtask

  task automatic test_stall();
    logic [2*W-1:0] exp;
    int bad;
    // MFLO right behind a MULT: stalled throughout, then returns the new LO.
    @(negedge clk);
    valid = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd4;
    sb_q.push_back({32'h0, 32'd12});
    @(negedge clk);
    valid = 1'b0; op = 3'd0; rd_req = 1'b1; rd_sel = 1'b0;
    bad = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mflo_stall: %0d cycles unstalled required 0", bad); end
    exp = sb_q.pop_front();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mflo_release: stall=%b required 0", stall); end
    checks++;
    if (rdata !== exp[W-1:0]) begin
      errors++; $display("FAIL mflo_data: got %h required %h", rdata, exp[W-1:0]);
    end
    rd_req = 1'b0;
    // MTHI held while a MULTU runs: stalled, then written once idle.
    @(negedge clk);
    valid = 1'b1; op = 3'd2; rs = 32'd2; rt = 32'd3;
    sb_q.push_back({32'hA5A5A5A5, 32'd6});
    @(negedge clk);
    op = 3'd5; rs = 32'hA5A5A5A5;
    bad = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mthi_stall: %0d cycles unstalled required 0", bad); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mthi_release: stall=%b required 0", stall); end
    @(negedge clk);
    valid = 1'b0; op = 3'd0;
    exp = sb_q.pop_front();
    check_hilo("mthi_write", exp[2*W-1:W], exp[W-1:0]);
  endtask

  task automatic test_flush();
    int nd;
    write_mt(3'd5, 32'h11111111);
    write_mt(3'd6, 32'h11111111);
    @(negedge clk);
    valid = 1'b1; op = 3'd1; rs = 32'd9; rt = 32'd9;
    @(negedge clk);
    valid = 1'b0; op = 3'd0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy=%b required 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL flush_done: %0d pulses required 0", nd); end
    check_hilo("flush_hilo", 32'h11111111, 32'h11111111);
    // Start presented together with flush in IDLE is dropped.
    valid = 1'b1; op = 3'd1; rs = 32'd2; rt = 32'd2; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; op = 3'd0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start: busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid = 1'b1; op = 3'd2; rs = 32'd7; rt = 32'd9;
    @(negedge clk);
    valid = 1'b0; op = 3'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: busy=%b required 0", busy); end
    check_hilo("rst_mid", '0, '0);
    run_op("multu_after_rst", 3'd2, 32'd5, 32'd6, 32'd0, 32'd30, 33);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
